obstacle_plotter: RTL and testbench

//  Datapath end of the game control handshake: receives draw from the control FSM, then autonomously

---
 rtl/obstacle_plotter_pkg.sv | 24 ++
 rtl/obstacle_plotter_square_scan.sv | 32 +++
 rtl/obstacle_plotter.sv | 138 +++++++++++++
 tb/tb_obstacle_plotter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_plotter_pkg.sv
// Shared definitions for the obstacle plotter: FSM state encoding,
// screen geometry and the colours written to the VGA adapter.
package obstacle_plotter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_DRAW,
    S_WAIT,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_BITS       = 8;
  localparam int Y_BITS       = 7;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_PLAYER = 3'b010;

endpackage

// File: rtl/obstacle_plotter_square_scan.sv
// Walks a SIZE x SIZE square one pixel per cycle in raster order while
// scan_en is high; col/row are the offsets of the current pixel and done
// flags the last pixel, after which the counter is back at zero.
module square_scan #(
  parameter int SIZE = 4,
  parameter int LOG  = $clog2(SIZE)
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           scan_en,
  output logic [LOG-1:0] col,
  output logic [LOG-1:0] row,
  output logic           done
);

  logic [2*LOG-1:0] pix;

  assign col  = pix[LOG-1:0];
  assign row  = pix[2*LOG-1:LOG];
  assign done = scan_en && (pix == '1);

  // Pixel index: advances while scanning, wraps to zero after the last pixel.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pix <= '0;
    end else if (scan_en) begin
      if (done) pix <= '0;
      else      pix <= pix + 1'b1;
    end
  end

endmodule

// File: rtl/obstacle_plotter.sv
// Animates a player square across the VGA frame after a draw request:
// erase, move one pixel right (optionally up/down), redraw, once per frame
// tick, and raises a sticky finish on reaching the right edge or hitting
// the fixed obstacle.
module obstacle_plotter
  import obstacle_plotter_pkg::*;
#(
  parameter int         SCREEN_W    = SCREEN_W_DEF,
  parameter int         SCREEN_H    = SCREEN_H_DEF,
  parameter int         SIZE        = 4,
  parameter int         START_Y     = 56,
  parameter int         FRAME_TICKS = 833333,
  parameter int         OBS_X       = 80,
  parameter int         OBS_Y       = 52,
  parameter int         OBS_W       = 8,
  parameter int         OBS_H       = 16,
  parameter logic [2:0] PLAYER_COL  = COL_PLAYER
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              draw,
  input  logic              up,
  input  logic              down,
  output logic              finish,
  output logic [X_BITS-1:0] vga_x,
  output logic [Y_BITS-1:0] vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot
);

  localparam int LOG = $clog2(SIZE);
  localparam int FW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [FW-1:0]     FRAME_LAST = FW'(FRAME_TICKS - 1);
  localparam logic [Y_BITS-1:0] Y_START    = Y_BITS'(START_Y);
  localparam logic [Y_BITS-1:0] Y_MAX      = Y_BITS'(SCREEN_H - SIZE);

  // Collision compares are done 9 bits wide so x+SIZE never overflows.
  localparam logic [8:0] SIZE_9   = 9'(SIZE);
  localparam logic [8:0] OBS_X0   = 9'(OBS_X);
  localparam logic [8:0] OBS_X1   = 9'(OBS_X + OBS_W);
  localparam logic [8:0] OBS_Y0   = 9'(OBS_Y);
  localparam logic [8:0] OBS_Y1   = 9'(OBS_Y + OBS_H);
  localparam logic [8:0] X_FINAL  = 9'(SCREEN_W - SIZE);

  state_t            state, next_state;
  logic [X_BITS-1:0] obj_x;
  logic [Y_BITS-1:0] obj_y;
  logic [FW-1:0]     frame_cnt;
  logic              scanning;
  logic [LOG-1:0]    scan_col, scan_row;
  logic              scan_done;
  logic [8:0]        x_9, y_9;
  logic              hit, at_end;

  assign scanning = (state == S_INIT_DRAW) || (state == S_ERASE) || (state == S_DRAW);

  assign x_9    = {1'b0, obj_x};
  assign y_9    = {2'b0, obj_y};
  assign hit    = (x_9 < OBS_X1) && (x_9 + SIZE_9 > OBS_X0) &&
                  (y_9 < OBS_Y1) && (y_9 + SIZE_9 > OBS_Y0);
  assign at_end = (x_9 == X_FINAL);

  square_scan #(.SIZE(SIZE), .LOG(LOG)) u_scan (
    .clock   (clock),
    .resetn  (resetn),
    .scan_en (scanning),
    .col     (scan_col),
    .row     (scan_row),
    .done    (scan_done)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state logic: draw is only looked at in IDLE, DONE is terminal.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (draw) next_state = S_INIT_DRAW;
      S_INIT_DRAW: if (scan_done) next_state = S_WAIT;
      S_WAIT:      if (frame_cnt == FRAME_LAST) next_state = S_ERASE;
      S_ERASE:     if (scan_done) next_state = S_MOVE;
      S_MOVE:      next_state = S_DRAW;
      S_DRAW:      if (scan_done) next_state = S_CHECK;
      S_CHECK:     next_state = (hit || at_end) ? S_DONE : S_WAIT;
      S_DONE:      next_state = S_DONE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Position, frame timer and sticky finish flag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      obj_x     <= '0;
      obj_y     <= Y_START;
      frame_cnt <= '0;
      finish    <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (frame_cnt == FRAME_LAST) frame_cnt <= '0;
          else                         frame_cnt <= frame_cnt + 1'b1;
        end
        S_MOVE: begin
          obj_x <= obj_x + 1'b1;
          if (up && !down && obj_y != '0)
            obj_y <= obj_y - 1'b1;
          else if (down && !up && obj_y < Y_MAX)
            obj_y <= obj_y + 1'b1;
        end
        S_CHECK: if (hit || at_end) finish <= 1'b1;
        default: ;
      endcase
    end
  end

  // Registered pixel port: the pixel scanned this cycle is presented next cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= COL_BLACK;
    end else begin
      vga_plot <= scanning;
      if (scanning) begin
        vga_x      <= obj_x + X_BITS'(scan_col);
        vga_y      <= obj_y + Y_BITS'(scan_row);
        vga_colour <= (state == S_ERASE) ? COL_BLACK : PLAYER_COL;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_plotter.sv
// Randomised self-checking bench for obstacle_plotter with a short frame
// tick; a pixel-stream monitor feeds a step-level model of the game.
module tb_obstacle_plotter;

  localparam int FT   = 4;
  localparam int SZ   = 4;
  localparam int SW   = 160;
  localparam int SH   = 120;
  localparam int SY   = 56;
  localparam int OX   = 80;
  localparam int OY   = 52;
  localparam int OW   = 8;
  localparam int OH   = 16;
  localparam int STEP = FT + 2 * SZ * SZ + 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       draw = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       finish;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } pix_t;

  pix_t plot_q[$];
  pix_t mon_p;

  obstacle_plotter #(
    .SCREEN_W(SW), .SCREEN_H(SH), .SIZE(SZ), .START_Y(SY), .FRAME_TICKS(FT),
    .OBS_X(OX), .OBS_Y(OY), .OBS_W(OW), .OBS_H(OH), .PLAYER_COL(3'b010)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .draw       (draw),
    .up         (up),
    .down       (down),
    .finish     (finish),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clock = ~clock;

  // Record every plotted pixel with its cycle number, sampled just after the edge.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (vga_plot !== 1'b0) begin
      mon_p.x = int'(vga_x);
      mon_p.y = int'(vga_y);
      mon_p.c = int'(vga_colour);
      mon_p.t = cyc;
      plot_q.push_back(mon_p);
    end
  end

  // Guard against a hung handshake.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic d, input logic u, input logic dn);
    draw = d;
    up   = u;
    down = dn;
  endtask

  function automatic int pack(input int x, input int y, input int c);
    return (x << 10) | (y << 3) | c;
  endfunction

  function automatic bit model_done(input int x, input int y);
    bit overlap;
    overlap = (x < OX + OW) && (x + SZ > OX) && (y < OY + OH) && (y + SZ > OY);
    return overlap || (x == SW - SZ);
  endfunction

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("rst_finish", finish, 0);
    checkOutput("rst_plot", vga_plot, 0);
    checkOutput("rst_xyc", pack(vga_x, vga_y, vga_colour), 0);
    resetn = 1'b1;
    @(negedge clock);
    plot_q.delete();
  endtask

  task automatic wait_plots(input int n, output bit ok);
    int waited = 0;
    while (plot_q.size() < n && waited < 120) begin
      @(negedge clock);
      waited++;
    end
    ok = (plot_q.size() >= n);
    if (!ok) checkOutput("plot_timeout", plot_q.size(), n);
  endtask

  task automatic check_square(input string tag, input int ox, input int oy, input int col,
                              output int t0);
    pix_t p;
    t0 = 0;
    for (int k = 0; k < SZ * SZ; k++) begin
      p = plot_q.pop_front();
      if (k == 0) t0 = p.t;
      checkOutput(tag, pack(p.x, p.y, p.c), pack(ox + k % SZ, oy + k / SZ, col));
      checkOutput({tag, "_cycle"}, p.t - t0, k);
    end
  endtask

  task automatic pulse_draw(input logic u, input logic dn);
    @(negedge clock);
    applyStimulus(1'b1, u, dn);
    @(negedge clock);
    applyStimulus(1'b0, u, dn);
  endtask

  // mode 0: idle inputs, 1: up held, 2: down held, 3: both held, 4: random
  task automatic run_case(input int mode);
    int  mx, my, step, t0, prev_t, r;
    bit  mfin, ok;
    logic u, dn;
    do_reset();
    mx = 0;
    my = SY;
    mfin = 1'b0;
    step = 0;
    prev_t = -1;
    pulse_draw(1'b0, 1'b0);
    wait_plots(SZ * SZ, ok);
    if (ok) check_square("init_pix", mx, my, 2, t0);
    while (ok && !mfin && step < 200) begin
      r  = $urandom_range(0, 3);
      u  = (mode == 1 || mode == 3) ? 1'b1 : (mode == 4) ? r[0] : 1'b0;
      dn = (mode == 2 || mode == 3) ? 1'b1 : (mode == 4) ? r[1] : 1'b0;
      if (step == 3) pulse_draw(u, dn);
      else applyStimulus(1'b0, u, dn);
      wait_plots(2 * SZ * SZ, ok);
      if (ok) begin
        check_square("erase_pix", mx, my, 0, t0);
        if (prev_t >= 0) checkOutput("step_period", t0 - prev_t, STEP);
        prev_t = t0;
        mx = mx + 1;
        if (u && !dn && my > 0) my = my - 1;
        else if (dn && !u && my < SH - SZ) my = my + 1;
        check_square("draw_pix", mx, my, 2, t0);
        mfin = model_done(mx, my);
        repeat (2) @(negedge clock);
        checkOutput("finish_step", finish, mfin);
      end
      step++;
    end
    $display("[TB] mode %0d ended at x=%0d y=%0d after %0d steps", mode, mx, my, step);
    repeat (60) @(negedge clock);
    checkOutput("done_no_plots", plot_q.size(), 0);
    checkOutput("done_finish_held", finish, 1);
  endtask

  task automatic reset_mid_erase();
    bit ok;
    do_reset();
    pulse_draw(1'b0, 1'b0);
    wait_plots(SZ * SZ, ok);
    plot_q.delete();
    wait_plots(3, ok);
    resetn = 1'b0;
    @(negedge clock);
    checkOutput("mid_rst_plot", vga_plot, 0);
    checkOutput("mid_rst_finish", finish, 0);
    resetn = 1'b1;
    plot_q.delete();
    repeat (40) @(negedge clock);
    checkOutput("mid_rst_idle_plots", plot_q.size(), 0);
  endtask

  initial begin
    $display("[TB] obstacle_plotter bench start");
    repeat (3) @(negedge clock);
    do_reset();
    repeat (50) @(negedge clock);
    checkOutput("idle_plots", plot_q.size(), 0);
    checkOutput("idle_finish", finish, 0);
    for (int m = 0; m < 6; m++) run_case((m >= 4) ? 4 : m);
    reset_mid_erase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
